// File: rtl/fifo_access_arbiter_pkg.sv
// rtl/fifo_access_arbiter_pkg.sv - shared types and default sizing for the frame-line FIFO arbiter
package fifo_arb_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int AW_DEFAULT    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_W = 2'b01,
    GNT_R = 2'b10
  } arb_state_e;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } winner_e;

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - request/grant and FIFO-port bundle between requesters and arbiter
interface fifo_access_arbiter_if #(
  parameter int AW = 6
);
  logic          wr_req;
  logic          rd_req;
  logic          wr_gnt;
  logic          rd_gnt;
  logic          we;
  logic          re;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          busy;

  modport master (
    output wr_req, rd_req,
    input  wr_gnt, rd_gnt, we, re, wr_addr, rd_addr, count, full, empty, busy
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_gnt, rd_gnt, we, re, wr_addr, rd_addr, count, full, empty, busy
  );
endinterface

// File: rtl/fifo_access_arbiter_req_sync.sv
// rtl/fifo_access_arbiter_req_sync.sv - 2-flop request synchronizer, async active-low reset to 0
module req_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin write/read arbiter and pointer keeper for the frame-line FIFO
// FIFO_ARB_REQ_SYNC_EN: pass both requests through req_sync before the FSM.
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fifo_access_arbiter_if.slave bus
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  arb_state_e    state_q, state_d;
  winner_e       last_win_q, last_win_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_req_s, rd_req_s;
  logic          full, empty, wr_ok, rd_ok;
  logic          we, re;

`ifdef FIFO_ARB_REQ_SYNC_EN
  req_sync u_wr_sync (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.wr_req), .q_o(wr_req_s));
  req_sync u_rd_sync (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.rd_req), .q_o(rd_req_s));
`else
  assign wr_req_s = bus.wr_req;
  assign rd_req_s = bus.rd_req;
`endif

  // count alone decides full/empty so equal pointers are never ambiguous
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wr_ok = wr_req_s && !full;
  assign rd_ok = rd_req_s && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_win_q <= READ;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    we         = 1'b0;
    re         = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ok && rd_ok) begin
          state_d = (last_win_q == READ) ? GNT_W : GNT_R;
        end else if (wr_ok) begin
          state_d = GNT_W;
        end else if (rd_ok) begin
          state_d = GNT_R;
        end
      end
      GNT_W: begin
        we         = 1'b1;
        wptr_d     = wptr_q + 1'b1;
        count_d    = count_q + 1'b1;
        last_win_d = WRITE;
        state_d    = IDLE;
      end
      GNT_R: begin
        re         = 1'b1;
        rptr_d     = rptr_q + 1'b1;
        count_d    = count_q - 1'b1;
        last_win_d = READ;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.we      = we;
  assign bus.re      = re;
  assign bus.wr_gnt  = we;
  assign bus.rd_gnt  = re;
  assign bus.wr_addr = wptr_q;
  assign bus.rd_addr = rptr_q;
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.busy    = (state_q == GNT_W) || (state_q == GNT_R);
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - directed self-checking bench for fifo_access_arbiter
module tb_fifo_access_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fifo_access_arbiter_if #(.AW(6)) bus ();

  fifo_access_arbiter #(.DEPTH(64), .AW(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int   we_cnt = 0, re_cnt = 0, overlap = 0, long_gnt = 0;
  logic wg_d = 1'b0, rg_d = 1'b0;

  always @(negedge clk) begin
    if (bus.we) we_cnt++;
    if (bus.re) re_cnt++;
    if (bus.we && bus.re) overlap++;
    if ((bus.wr_gnt && wg_d) || (bus.rd_gnt && rg_d)) long_gnt++;
    wg_d = bus.wr_gnt;
    rg_d = bus.rd_gnt;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: write grant, 1: read grant, 2: either; kind 1=W, 2=R
  task automatic wait_gnt(input int mode, input int budget, output int cyc,
                          output logic [5:0] addr, output bit ok, output int kind);
    ok = 1'b0; cyc = 0; addr = '0; kind = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.wr_gnt && mode != 1) begin
        ok = 1'b1; kind = 1; addr = bus.wr_addr;
      end else if (bus.rd_gnt && mode != 0) begin
        ok = 1'b1; kind = 2; addr = bus.rd_addr;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, kind, w0, r0, bad;
    logic [5:0] a;
    bit         ok;
    int         exp_kind [4];
    int         exp_addr [4];
    int         exp_cnt  [4];
    exp_kind = '{1, 2, 1, 2};
    exp_addr = '{7, 5, 8, 6};
    exp_cnt  = '{3, 2, 3, 2};

    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_full", bus.full, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_we_re", {bus.we, bus.re, bus.wr_gnt, bus.rd_gnt}, 0);
    check_eq("rst_addrs", {bus.wr_addr, bus.rd_addr}, 0);
    rst_n = 1'b1;
    w0 = we_cnt; r0 = re_cnt;
    repeat (5) @(negedge clk);
    check_eq("idle_no_pulses", (we_cnt - w0) + (re_cnt - r0), 0);
    check_eq("idle_empty", bus.empty, 1);

    // three held writes, 2 cycles apart
    bus.wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(0, 8, cyc, a, ok, kind);
      check_eq("wr3_ok", ok, 1);
      check_eq("wr3_addr", a, i);
      check_eq("wr3_spacing", cyc, (i == 0) ? 1 : 2);
      if (i == 2) begin
        check_eq("wr3_count_in_grant", bus.count, 2);
        bus.wr_req = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("wr3_count", bus.count, 3);
    check_eq("wr3_not_empty", bus.empty, 0);

    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1, 8, cyc, a, ok, kind);
      check_eq("rd3_addr", a, i);
      if (i == 2) bus.rd_req = 1'b0;
    end
    @(negedge clk);
    check_eq("drain_count", bus.count, 0);
    check_eq("drain_empty", bus.empty, 1);

    // read held on empty waits for a write
    r0 = re_cnt;
    bus.rd_req = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rd_held_empty", re_cnt - r0, 0);
    bus.wr_req = 1'b1;
    wait_gnt(0, 8, cyc, a, ok, kind);
    check_eq("unblock_wr_addr", a, 3);
    bus.wr_req = 1'b0;
    wait_gnt(1, 8, cyc, a, ok, kind);
    check_eq("unblock_rd_ok", ok, 1);
    check_eq("unblock_rd_addr", a, 3);
    check_eq("unblock_rd_lat", cyc, 2);
    bus.rd_req = 1'b0;
    @(negedge clk);
    check_eq("unblock_count", bus.count, 0);

    // leave count=2 with a read as the last winner
    bus.wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(0, 8, cyc, a, ok, kind);
      if (i == 2) bus.wr_req = 1'b0;
    end
    @(negedge clk);
    bus.rd_req = 1'b1;
    wait_gnt(1, 8, cyc, a, ok, kind);
    check_eq("pre_rr_rd_addr", a, 4);
    bus.rd_req = 1'b0;
    @(negedge clk);
    check_eq("pre_rr_count", bus.count, 2);

    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(2, 8, cyc, a, ok, kind);
      check_eq("rr_kind", kind, exp_kind[g]);
      check_eq("rr_addr", a, exp_addr[g]);
      if (g == 3) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
      @(negedge clk);
      check_eq("rr_count", bus.count, exp_cnt[g]);
    end

    // fill to 64 with wr_req left asserted
    bad = 0;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 62; i++) begin
      wait_gnt(0, 8, cyc, a, ok, kind);
      if (!ok || a != 6'((9 + i) % 64)) bad++;
    end
    check_eq("fill_addrs", bad, 0);
    @(negedge clk);
    check_eq("fill_count", bus.count, 64);
    check_eq("fill_full", bus.full, 1);
    w0 = we_cnt;
    repeat (4) @(negedge clk);
    check_eq("full_withheld", we_cnt - w0, 0);
    bus.rd_req = 1'b1;
    wait_gnt(1, 8, cyc, a, ok, kind);
    check_eq("full_rd_addr", a, 7);
    bus.rd_req = 1'b0;
    wait_gnt(0, 8, cyc, a, ok, kind);
    check_eq("full_pending_wr", ok, 1);
    check_eq("full_pending_addr", a, 7);
    check_eq("full_pending_lat", cyc, 2);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check_eq("refull_count", bus.count, 64);
    check_eq("refull_full", bus.full, 1);

    // reset in the middle of a write grant
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 6; i++) wait_gnt(0, 8, cyc, a, ok, kind);
    check_eq("pre_rst_addr", a, 5);
    check_eq("pre_rst_count", bus.count, 5);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_we", {bus.we, bus.wr_gnt, bus.busy}, 0);
    check_eq("midrst_count", bus.count, 0);
    check_eq("midrst_wptr", bus.wr_addr, 0);
    bus.wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_empty", bus.empty, 1);
    bus.wr_req = 1'b1;
    wait_gnt(0, 8, cyc, a, ok, kind);
    check_eq("post_rst_addr", a, 0);
    check_eq("post_rst_lat", cyc, 1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check_eq("post_rst_count", bus.count, 1);

    check_eq("we_re_exclusive", overlap, 0);
    check_eq("gnt_single_cycle", long_gnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Arbiter and sequencer for the 64-entry frame-line FIFO in the VGA path. It shares the FIFO's single access port between a write requester (pixel/button producer) and a read requester (display consumer). It grants round-robin, one access at a time, and generates single-cycle write/read enables with their addresses. It owns the write/read pointers, occupancy count and full/empty flags, and never lets a write proceed when full or a read proceed when empty.

## Interface
- DEPTH, 64, FIFO entries; must be a power of two
- AW, 6, address width, equal to log2(DEPTH)
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- wr_req  in  1  write request, level; held until wr_gnt seen
- rd_req  in  1  read request, level; held until rd_gnt seen
- wr_gnt  out  1  one-cycle write grant; coincident with we
- rd_gnt  out  1  one-cycle read grant; coincident with re
- we  out  1  FIFO write enable, one cycle per granted write
- re  out  1  FIFO read enable, one cycle per granted read
- wr_addr  out  AW  write pointer, valid while we=1
- rd_addr  out  AW  read pointer, valid while re=1
- count  out  AW+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, GNT_W, GNT_R; encoding 2 bits; default/illegal state goes to IDLE with all outputs low.
- IDLE: evaluate eligible requests.
  - wr_req eligible only if !full.
  - rd_req eligible only if !empty.
  - One eligible request: go to the matching GNT state.
  - Both eligible: grant the side opposite last_win (round-robin); last_win resets to READ, so the first contended grant is a write.
- GNT_W: we=1, wr_gnt=1, wr_addr=wptr. On exit: wptr+1 (mod DEPTH), count+1, last_win=WRITE, go to IDLE.
- GNT_R: re=1, rd_gnt=1, rd_addr=rptr. On exit: rptr+1 (mod DEPTH), count-1, last_win=READ, go to IDLE.
- Ineligible requests stay pending; no error flag, no drop. A write held while full is granted once a read frees space; a read held while empty is granted once a write lands.
- A requester still asserting req in the cycle after its grant is treated as a new request.
- full and empty are combinational from count; wr_addr and rd_addr show the pointers continuously.
- Pointers wrap 63->0 naturally. count is the sole full/empty source; pointer equality is not used.

## Timing
- Reset values: state=IDLE; wptr=0, rptr=0, count=0, last_win=READ; we, re, wr_gnt, rd_gnt, busy=0; empty=1, full=0; wr_addr=0, rd_addr=0.
- Latency from req sampled high in IDLE to grant/enable is 1 cycle.
- Each access occupies 2 cycles (grant + return to IDLE), so throughput is at most 1 access per 2 cycles.
- we and re are never high in the same cycle; gnt never lasts more than 1 cycle.
- count, full and empty update on the clock edge ending the grant cycle.
- Reset asserted mid-grant: outputs drop asynchronously and the in-flight access is not counted.

## Configuration
- FIFO_ARB_REQ_SYNC_EN defined: wr_req and rd_req each pass through a 2-flop synchronizer before the FSM, adding 2 cycles to request latency (3 cycles req->gnt). Used when requests come from push-buttons or another clock domain.
- FIFO_ARB_REQ_SYNC_EN undefined: requests feed the FSM directly, with 1-cycle latency.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum type (IDLE, GNT_W, GNT_R)
  - the winner enum (WRITE, READ)
  - the default DEPTH/AW constants
- Sub-module req_sync is the 2-flop synchronizer with async active-low reset to 0. It is instantiated twice, only under FIFO_ARB_REQ_SYNC_EN.
- Top level contains the FSM, pointers, count and round-robin flag.

## Test plan
- Reset, then idle 5 cycles -> empty=1, full=0, count=0, no we/re pulses.
- wr_req held for 3 grants (dropped after 3rd wr_gnt) -> we pulses at wr_addr 0,1,2, 2 cycles apart; count=3.
- rd_req held while count=0 -> no rd_gnt; then one write is granted -> rd_gnt follows with rd_addr=0; count returns to 0.
- Both requests held continuously with count=2 -> grants alternate W,R,W,R starting with W; count oscillates 3,2,3,2.
- 64 writes then wr_req still held -> full=1, wr_gnt withheld; one read granted -> the pending write is granted at wr_addr=0 (wrap), count=64 again.
- reset pulled low during GNT_W after 5 writes -> we drops immediately; after release count=0, wptr=0.
